// File: rtl/shot_resolver_fsm.sv
// Opponent-board shot resolver: accepts shots on a valid/ready handshake and resolves each one in a fixed 2-cycle pipeline.
// Optional shot budget enabled by defining SHOT_LIMIT_EN (adds the out_of_shots port).
module shot_resolver_fsm #(
    parameter  int N         = 5,
    parameter  int CW        = 3,
    parameter  int SCW       = 8,
    parameter  int MAX_SHOTS = 20,
    localparam int XW        = (N > 2) ? $clog2(N) : 1,
    localparam int SLW       = $clog2(N*N+1),
    localparam int BW        = N*N*CW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [BW-1:0]  board_in,
    input  logic           shot_valid,
    output logic           shot_ready,
    input  logic [XW-1:0]  shot_x,
    input  logic [XW-1:0]  shot_y,
    output logic           res_valid,
    output logic [1:0]     res_code,
    output logic [BW-1:0]  board_out,
    output logic [SLW-1:0] ships_left,
    output logic [SCW-1:0] shots_taken,
    output logic           game_over,
`ifdef SHOT_LIMIT_EN
    output logic           out_of_shots,
`endif
    output logic [2:0]     state_dbg
);

    localparam int IW = (N*N > 2) ? $clog2(N*N) : 1;

    localparam logic [CW-1:0] C_WATER = CW'(3'b001);
    localparam logic [CW-1:0] C_SHIP  = CW'(3'b010);
    localparam logic [CW-1:0] C_HIT   = CW'(3'b111);
    localparam logic [CW-1:0] C_NHIT  = CW'(3'b100);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RESOLVE = 3'd2,
        REPORT  = 3'd3,
        OVER    = 3'd4
    } state_t;

    state_t         state;
    logic [CW-1:0]  cells [N*N];
    logic [XW-1:0]  x_q;
    logic [XW-1:0]  y_q;
    logic [SLW-1:0] load_ships;
    logic           in_range;
    logic [IW-1:0]  cell_idx;
    logic [CW-1:0]  cur_cell;

    // Handshake: a shot transfers on a rising edge where shot_valid && shot_ready;
    // shot_ready depends only on state, never on shot_valid.
    assign shot_ready = (state == ARMED);
    assign state_dbg  = state;

    for (genvar g = 0; g < N*N; g++) begin : g_pack
        assign board_out[g*CW +: CW] = cells[g];
    end

    always_comb begin
        load_ships = '0;
        for (int i = 0; i < N*N; i++) begin
            if (board_in[i*CW +: CW] == C_SHIP) load_ships = load_ships + SLW'(1);
        end
    end

    // Out-of-range coordinates never address the array; they resolve as invalid.
    always_comb begin
        in_range = ({1'b0, x_q} < (XW+1)'(N)) && ({1'b0, y_q} < (XW+1)'(N));
        cell_idx = in_range ? IW'(int'(x_q) * N + int'(y_q)) : '0;
        cur_cell = cells[cell_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int i = 0; i < N*N; i++) cells[i] <= C_WATER;
            x_q         <= '0;
            y_q         <= '0;
            res_valid   <= 1'b0;
            res_code    <= 2'b00;
            ships_left  <= '0;
            shots_taken <= '0;
            game_over   <= 1'b0;
`ifdef SHOT_LIMIT_EN
            out_of_shots <= 1'b0;
`endif
        end else if (load) begin
            for (int i = 0; i < N*N; i++) cells[i] <= board_in[i*CW +: CW];
            ships_left  <= load_ships;
            shots_taken <= '0;
            game_over   <= (load_ships == '0);
            res_valid   <= 1'b0;
            state       <= (load_ships == '0) ? OVER : ARMED;
`ifdef SHOT_LIMIT_EN
            out_of_shots <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: ;
                ARMED: begin
                    if (shot_valid) begin
                        x_q   <= shot_x;
                        y_q   <= shot_y;
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    res_valid <= 1'b1;
                    state     <= REPORT;
                    if (!in_range) begin
                        res_code <= 2'b11;
                    end else if (cur_cell == C_SHIP) begin
                        cells[cell_idx] <= C_HIT;
                        res_code        <= 2'b01;
                        ships_left      <= ships_left - SLW'(1);
                        if (shots_taken != '1) shots_taken <= shots_taken + SCW'(1);
                    end else if (cur_cell == C_HIT || cur_cell == C_NHIT) begin
                        res_code <= 2'b10;
                    end else begin
                        cells[cell_idx] <= C_NHIT;
                        res_code        <= 2'b00;
                        if (shots_taken != '1) shots_taken <= shots_taken + SCW'(1);
                    end
                end
                REPORT: begin
                    res_valid <= 1'b0;
                    if (ships_left == '0) begin
                        game_over <= 1'b1;
                        state     <= OVER;
`ifdef SHOT_LIMIT_EN
                    end else if (shots_taken == SCW'(MAX_SHOTS)) begin
                        out_of_shots <= 1'b1;
                        state        <= OVER;
`endif
                    end else begin
                        state <= ARMED;
                    end
                end
                OVER: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shot_resolver_fsm.md
Name: shot_resolver_fsm

Overview:
- Parametrised successor of the single-cycle player-shot update logic.
- Holds the opponent board internally and accepts shots through a valid/ready handshake.
- Resolves each shot in a fixed 2-cycle pipeline, detects repeat and out-of-range shots, and tracks ships remaining, shots taken and game over.
- Sits between the turn/input controller and the VGA board renderer.

Parameters:
- N, 5, board dimension; board is N x N, N in 2..16.
- CW, 3, bits per cell state.
- SCW, 8, width of shots_taken counter (saturating).
- MAX_SHOTS, 20, shot budget; used only with SHOT_LIMIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  one-cycle pulse; capture board_in.
- board_in  in  N*N*CW  flat board; cell (i,j) at bits [(i*N+j)*CW +: CW].
- shot_valid  in  1  shot request.
- shot_ready  out  1  block can accept a shot.
- shot_x  in  XW=max(1,$clog2(N))  row index.
- shot_y  in  XW  column index.
- res_valid  out  1  one-cycle result strobe.
- res_code  out  2  00 miss, 01 hit, 10 repeat, 11 invalid.
- board_out  out  N*N*CW  current internal board, same packing as board_in.
- ships_left  out  $clog2(N*N+1)  count of SHIP cells remaining.
- shots_taken  out  SCW  count of accepted miss/hit shots.
- game_over  out  1  all ships sunk.

Behaviour:
- Cell encodings: WATER=001, SHIP=010, HIT=111, NHIT=100. Any other value is treated as water.
- Reset (rst_n=0, async) sets:
  - state IDLE, board all WATER;
  - shot_ready=0, res_valid=0, res_code=00;
  - ships_left=0, shots_taken=0, game_over=0.
- States: IDLE, ARMED, RESOLVE, REPORT, OVER.
- IDLE: shot_ready=0. On load, go to ARMED, or to OVER if the loaded board has zero SHIP cells.
- load in any state:
  - board<=board_in; ships_left<=popcount of SHIP cells; shots_taken<=0; game_over<=(count==0); res_valid<=0.
  - load has priority over any shot in flight; an aborted shot produces no result.
- ARMED: shot_ready=1 (combinational from state). On edge E0 with shot_valid&&shot_ready, register x,y and go to RESOLVE.
- RESOLVE, edge E1:
  - x>=N or y>=N: res_code=11; board and counters unchanged.
  - cell==SHIP: cell<=HIT; res_code=01; ships_left-1; shots_taken+1.
  - cell HIT or NHIT: res_code=10; no change.
  - otherwise: cell<=NHIT; res_code=00; shots_taken+1.
  - res_valid<=1; go to REPORT.
- REPORT, edge E2: res_valid<=0. Go to OVER if ships_left==0, else ARMED.
- Timing: result appears 2 cycles after acceptance, res_valid high exactly 1 cycle, maximum throughput 1 shot per 3 cycles.
- res_code holds its value until the next result.
- OVER: game_over=1, shot_ready=0, shot_valid ignored. Exit only via load or reset.
- shots_taken saturates at 2^SCW-1.
- board_out and ships_left are updated on E1, in the same cycle res_valid rises.
- shot_x/shot_y may change freely after acceptance.

Optional Feature:
- Macro SHOT_LIMIT_EN.
- When defined:
  - extra output out_of_shots (1 bit, reset 0).
  - In REPORT, if shots_taken==MAX_SHOTS and ships_left!=0: out_of_shots<=1 and go to OVER; game_over stays 0.
  - load clears out_of_shots.
- When undefined: port absent, MAX_SHOTS unused, unlimited shots.

Test Plan:
- Reset, then load board with SHIP at (1,2) and (3,3), rest WATER -> ships_left=2, shot_ready=1 next cycle, game_over=0.
- Shot (1,2) accepted at E0 -> res_valid=1 at E0+2 cycles for 1 cycle, res_code=01, cell(1,2)=111, ships_left=1, shots_taken=1.
- Shot (0,0), then shot (0,0) again -> first gives res_code=00 and cell=100, shots_taken=2; second gives res_code=10, shots_taken stays 2.
- Shot (5,1) with N=5 -> res_code=11, board, ships_left and shots_taken unchanged; then shot (3,3) -> res_code=01, ships_left=0, game_over=1, shot_ready=0; further shot_valid ignored.
- load asserted in RESOLVE cycle -> no res_valid; board=board_in, counters reset. Async rst_n pulse mid-REPORT -> all outputs return to reset values immediately.
- SHOT_LIMIT_EN with MAX_SHOTS=3, three misses -> out_of_shots=1 after third REPORT, game_over=0, shot_ready=0.
